// File: rtl/mem_pkg.sv
// Shared types and sizing for the MEM pipeline stage: FSM states, widths and
// the default memory timeout.
package mem_pkg;

  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;
  localparam int REG_W           = 5;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch resolution: decides whether the fetch prediction was wrong and which
// PC fetch must restart from.
module branch_resolve
  import mem_pkg::*;
(
  input  logic              branch,
  input  logic              zero,
  input  logic              predict_taken,
  input  logic [ADDR_W-1:0] pc_branch,
  input  logic [ADDR_W-1:0] pc_4,
  input  logic              hold,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc
);

  logic actual_s;

  assign actual_s    = branch & zero;
  // hold covers reset, a stalled stage and the illegal branch+memop combination
  assign flush       = branch & (actual_s != predict_taken) & ~hold;
  assign redirect_pc = actual_s ? pc_branch : pc_4;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory handshake, stalls the pipe while
// an access is outstanding, and registers the MEM/WB writeback fields.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Mem_Read_EX_MEM,
  input  logic              Mem_Write_EX_MEM,
  input  logic              Reg_Write_EX_MEM,
  input  logic              PcSrc_EX_MEM,
  input  logic              zero_EX_MEM,
  input  logic [ADDR_W-1:0] PC_Branch_EX_MEM,
  input  logic [ADDR_W-1:0] PC_4_EX_MEM,
  input  logic              Predict_Taken_EX_MEM,
  input  logic [DATA_W-1:0] result_EX_MEM,
  input  logic [DATA_W-1:0] Write_Data_EX_MEM,
  input  logic [REG_W-1:0]  rd_EX_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              Reg_Write_MEM_WB,
  output logic [DATA_W-1:0] wb_data_MEM_WB,
  output logic [REG_W-1:0]  rd_MEM_WB,
  output logic              mem_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state_r;
  logic [CNT_W-1:0] count_r;

  logic memop_s;
  logic aligned_s;
  logic busy_s;
  logic timeout_s;
  logic misalign_s;
  logic error_s;
  logic stall_s;
  logic hold_s;

  assign memop_s    = Mem_Read_EX_MEM | Mem_Write_EX_MEM;
  assign aligned_s  = is_aligned(result_EX_MEM);
  assign busy_s     = (state_r == BUSY);
  // rvalid on the last allowed cycle still completes the access normally
  assign timeout_s  = busy_s & (count_r == CNT_W'(TIMEOUT - 1)) & ~dmem_rvalid;
  assign misalign_s = memop_s & ~aligned_s;
  assign error_s    = timeout_s | misalign_s;
  assign stall_s    = rst_n & memop_s & aligned_s & ~(busy_s & (dmem_rvalid | timeout_s));
  assign hold_s     = ~rst_n | stall_s | memop_s;
  assign stall      = stall_s;

  branch_resolve u_branch_resolve (
    .branch        (PcSrc_EX_MEM),
    .zero          (zero_EX_MEM),
    .predict_taken (Predict_Taken_EX_MEM),
    .pc_branch     (PC_Branch_EX_MEM),
    .pc_4          (PC_4_EX_MEM),
    .hold          (hold_s),
    .flush         (flush),
    .redirect_pc   (redirect_pc)
  );

  // Memory FSM, timeout counter, request registers and MEM/WB register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      count_r          <= '0;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_wdata       <= '0;
      Reg_Write_MEM_WB <= 1'b0;
      wb_data_MEM_WB   <= '0;
      rd_MEM_WB        <= '0;
      mem_err          <= 1'b0;
    end else begin
      mem_err <= error_s;
      if (!stall_s) begin
        Reg_Write_MEM_WB <= Reg_Write_EX_MEM & ~error_s;
        rd_MEM_WB        <= rd_EX_MEM;
        wb_data_MEM_WB   <= Mem_Read_EX_MEM ? dmem_rdata : result_EX_MEM;
      end else begin
        Reg_Write_MEM_WB <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (memop_s && aligned_s) begin
            state_r    <= BUSY;
            count_r    <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= Mem_Write_EX_MEM;
            dmem_addr  <= result_EX_MEM;
            dmem_wdata <= Write_Data_EX_MEM;
          end else begin
            state_r  <= IDLE;
            dmem_req <= 1'b0;
          end
        end
        BUSY: begin
          if (dmem_rvalid || timeout_s) begin
            state_r  <= IDLE;
            dmem_req <= 1'b0;
          end else begin
            count_r <= count_r + CNT_W'(1);
          end
        end
        default: begin
          state_r  <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
